// File: rtl/sdram_arb_pkg.sv
// sdram_arbiter shared definitions.
// State codes, grant encoding and default widths.
package sdram_arb_pkg;

  localparam int DEF_ADDR_WIDTH     = 23;
  localparam int DEF_DATA_WIDTH     = 128;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  localparam int DEF_TIMEOUT_WIDTH  = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_WAIT = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    RD_REQ  = ST_RD_REQ,
    RD_WAIT = ST_RD_WAIT,
    WR_REQ  = ST_WR_REQ,
    WR_WAIT = ST_WR_WAIT,
    DONE    = ST_DONE
  } state_t;

  localparam logic GRANT_READ  = 1'b0;
  localparam logic GRANT_WRITE = 1'b1;

  typedef enum logic {
    READ  = GRANT_READ,
    WRITE = GRANT_WRITE
  } grant_t;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Requester and controller signals of sdram_arbiter.
// slave = arbiter view, master = environment view.
interface sdram_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_done;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_done;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_rd_enable;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic                  mem_wr_enable;
  logic                  mem_busy;
  logic                  mem_rd_ready;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  arb_busy;
  logic                  timeout_err;

  modport slave (
    input  rd_req, rd_addr,
    input  wr_req, wr_addr, wr_data,
    input  mem_busy, mem_rd_ready, mem_rd_data,
    output rd_done, rd_data, wr_done,
    output mem_rd_addr, mem_rd_enable,
    output mem_wr_addr, mem_wr_data, mem_wr_enable,
    output arb_busy, timeout_err
  );

  modport master (
    output rd_req, rd_addr,
    output wr_req, wr_addr, wr_data,
    output mem_busy, mem_rd_ready, mem_rd_data,
    input  rd_done, rd_data, wr_done,
    input  mem_rd_addr, mem_rd_enable,
    input  mem_wr_addr, mem_wr_data, mem_wr_enable,
    input  arb_busy, timeout_err
  );

endinterface

// File: rtl/sdram_arbiter.sv
// Two-requester arbiter in front of the SDRAM controller port.
// Alternates on contention; a watchdog aborts stuck transfers.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TIMEOUT_WIDTH  = DEF_TIMEOUT_WIDTH
) (
  input  logic           sys_clk,
  input  logic           rst,
  sdram_arbiter_if.slave bus
);

  localparam logic [TIMEOUT_WIDTH-1:0] WDOG_MAX =
    TIMEOUT_CYCLES[TIMEOUT_WIDTH-1:0];

  state_t state_q, state_d;
  grant_t last_q, last_d;

  logic [TIMEOUT_WIDTH-1:0] wdog_q, wdog_d;

  logic rd_en_q, rd_en_d;
  logic wr_en_q, wr_en_d;
  logic rd_done_q, rd_done_d;
  logic wr_done_q, wr_done_d;
  logic err_q, err_d;
  logic busy_q, busy_d;

  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic rd_win, wr_win;
  logic wdog_hit, counting;
  logic to_rd, to_wr;

  // Contention goes to the type opposite the last contended grant
  assign rd_win = bus.rd_req &&
    (!bus.wr_req || last_q == WRITE);
  assign wr_win = bus.wr_req &&
    (!bus.rd_req || last_q == READ);

  assign wdog_hit = (wdog_q == WDOG_MAX);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    rd_en_d   = rd_en_q;
    wr_en_d   = wr_en_q;
    rd_done_d = 1'b0;
    wr_done_d = 1'b0;
    err_d     = err_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    to_rd     = 1'b0;
    to_wr     = 1'b0;
    counting  = 1'b0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          rd_win: begin
            rd_addr_d = bus.rd_addr;
            rd_en_d   = 1'b1;
            state_d   = RD_REQ;
            if (bus.wr_req) last_d = READ;
          end
          wr_win: begin
            wr_addr_d = bus.wr_addr;
            wr_data_d = bus.wr_data;
            wr_en_d   = 1'b1;
            state_d   = WR_REQ;
            if (bus.rd_req) last_d = WRITE;
          end
          default: ;
        endcase
      end
      RD_REQ: begin
        counting = 1'b1;
        if (bus.mem_busy) begin
          rd_en_d = 1'b0;
          state_d = RD_WAIT;
        end else if (wdog_hit) begin
          to_rd = 1'b1;
        end
      end
      RD_WAIT: begin
        counting = 1'b1;
        if (bus.mem_rd_ready) begin
          rd_data_d = bus.mem_rd_data;
          rd_done_d = 1'b1;
          state_d   = DONE;
        end else if (wdog_hit) begin
          to_rd = 1'b1;
        end
      end
      WR_REQ: begin
        counting = 1'b1;
        if (bus.mem_busy) begin
          wr_en_d = 1'b0;
          state_d = WR_WAIT;
        end else if (wdog_hit) begin
          to_wr = 1'b1;
        end
      end
      WR_WAIT: begin
        counting = 1'b1;
        if (!bus.mem_busy) begin
          wr_done_d = 1'b1;
          state_d   = DONE;
        end else if (wdog_hit) begin
          to_wr = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort leaves rd_data untouched
    if (to_rd || to_wr) begin
      rd_en_d   = 1'b0;
      wr_en_d   = 1'b0;
      err_d     = 1'b1;
      rd_done_d = to_rd;
      wr_done_d = to_wr;
      state_d   = DONE;
    end

    if (state_d != state_q || !counting)
      wdog_d = '0;
    else
      wdog_d = wdog_q + 1'b1;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= WRITE;
      wdog_q    <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wdog_q    <= wdog_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.mem_rd_addr   = rd_addr_q;
  assign bus.mem_rd_enable = rd_en_q;
  assign bus.mem_wr_addr   = wr_addr_q;
  assign bus.mem_wr_data   = wr_data_q;
  assign bus.mem_wr_enable = wr_en_q;
  assign bus.rd_done       = rd_done_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.wr_done       = wr_done_q;
  assign bus.arb_busy      = busy_q;
  assign bus.timeout_err   = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter.
// Controller model, grant/done monitor, directed requesters.
module tb_sdram_arbiter;

  localparam int AW = 23;
  localparam int DW = 128;
  localparam int TO = 255;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;

  always #5 sys_clk = ~sys_clk;

  sdram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sdram_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_WIDTH(8)
  ) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  typedef enum int {M_NORMAL, M_NO_BUSY, M_NO_READY} mmode_t;

  txn_t grant_q[$];
  txn_t done_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  mmode_t        mode          = M_NORMAL;
  logic [DW-1:0] model_rd_data = '0;
  int            busy_fall_cyc = -100;
  int            last_done_cyc = -1;
  int            last_grant_cyc = -1;
  int            grant_cnt     = 0;
  logic          chk_gap       = 1'b0;

  always @(posedge sys_clk) cyc++;

  task automatic check(input string name,
                       input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_txn(input logic is_wr,
                          input logic [AW-1:0] a,
                          input logic [DW-1:0] d,
                          input logic [DW-1:0] dd);
    txn_t t;
    t.is_wr = is_wr;
    t.addr  = a;
    t.data  = d;
    grant_q.push_back(t);
    t.data  = dd;
    done_q.push_back(t);
  endtask

  task automatic wait_done(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge sys_clk);
      if (bus.rd_done || bus.wr_done) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_done: no done within %0d cycles", maxc);
  endtask

  // Controller model
  initial begin : model
    logic is_rd;
    bus.mem_busy     = 1'b0;
    bus.mem_rd_ready = 1'b0;
    bus.mem_rd_data  = '0;
    forever begin
      @(posedge sys_clk);
      #1;
      if (rst || mode == M_NO_BUSY) continue;
      if (!(bus.mem_rd_enable || bus.mem_wr_enable)) continue;
      is_rd = bus.mem_rd_enable;
      repeat (3) @(posedge sys_clk);
      #1;
      bus.mem_busy = 1'b1;
      @(negedge sys_clk);
      check("en_held_until_busy",
            is_rd ? bus.mem_rd_enable : bus.mem_wr_enable, 1);
      @(negedge sys_clk);
      check("en_drop_after_busy",
            is_rd ? bus.mem_rd_enable : bus.mem_wr_enable, 0);
      if (is_rd && mode == M_NO_READY) begin
        for (int i = 0; i < 2000 && !rst; i++)
          @(posedge sys_clk);
        #1;
        bus.mem_busy = 1'b0;
      end else if (is_rd) begin
        repeat (9) @(posedge sys_clk);
        #1;
        bus.mem_rd_ready = 1'b1;
        bus.mem_rd_data  = model_rd_data;
        @(posedge sys_clk);
        #1;
        bus.mem_rd_ready = 1'b0;
        bus.mem_rd_data  = '0;
        bus.mem_busy     = 1'b0;
      end else begin
        repeat (5) @(posedge sys_clk);
        #1;
        bus.mem_busy  = 1'b0;
        busy_fall_cyc = cyc;
      end
    end
  end

  // Monitor / scoreboard
  initial begin : monitor
    logic pr_en, pw_en, pr_done, pw_done;
    logic r_rise, w_rise;
    txn_t t;
    pr_en = 0; pw_en = 0; pr_done = 0; pw_done = 0;
    forever begin
      @(negedge sys_clk);
      r_rise = bus.mem_rd_enable && !pr_en;
      w_rise = bus.mem_wr_enable && !pw_en;
      if (r_rise || w_rise) begin
        grant_cnt++;
        if (chk_gap && last_done_cyc >= 0)
          check("grant_gap", cyc - last_done_cyc, 2);
        last_grant_cyc = cyc;
        if (grant_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant: got wr=%0d expected none",
                   w_rise);
        end else begin
          t = grant_q.pop_front();
          check("grant_type", w_rise, t.is_wr);
          check("grant_addr",
                t.is_wr ? bus.mem_wr_addr : bus.mem_rd_addr, t.addr);
          if (t.is_wr)
            check("grant_wdata", bus.mem_wr_data, t.data);
        end
      end
      if (pr_done) check("rd_done_width", bus.rd_done, 0);
      if (pw_done) check("wr_done_width", bus.wr_done, 0);
      if (bus.rd_done || bus.wr_done) begin
        last_done_cyc = cyc;
        if (done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got rd=%0d wr=%0d expected none",
                   bus.rd_done, bus.wr_done);
        end else begin
          t = done_q.pop_front();
          check("done_type", {bus.rd_done, bus.wr_done},
                t.is_wr ? 2'b01 : 2'b10);
          if (!t.is_wr)
            check("rd_data", bus.rd_data, t.data);
        end
      end
      pr_en   = bus.mem_rd_enable;
      pw_en   = bus.mem_wr_enable;
      pr_done = bus.rd_done;
      pw_done = bus.wr_done;
    end
  end

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  localparam logic [DW-1:0] D0 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [DW-1:0] D1 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
  localparam logic [DW-1:0] D2 = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
  localparam logic [DW-1:0] D3 = 128'hDEADBEEF_00000001_80000000_CAFEF00D;

  initial begin : stim
    int gc;
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;

    repeat (3) @(negedge sys_clk);
    check("rst_arb_busy", bus.arb_busy, 0);
    check("rst_rd_en", bus.mem_rd_enable, 0);
    check("rst_wr_en", bus.mem_wr_enable, 0);
    check("rst_err", bus.timeout_err, 0);
    check("rst_rd_data", bus.rd_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    // Contention from reset: R,W,R,W with both held
    model_rd_data = D1;
    push_txn(0, 23'h000100, '0, D1);
    push_txn(1, 23'h7FFFFF, D2, '0);
    push_txn(0, 23'h000100, '0, D1);
    push_txn(1, 23'h7FFFFF, D2, '0);
    chk_gap       = 1'b1;
    last_done_cyc = -1;
    bus.rd_addr = 23'h000100;
    bus.wr_addr = 23'h7FFFFF;
    bus.wr_data = D2;
    bus.rd_req  = 1'b1;
    bus.wr_req  = 1'b1;
    repeat (4) wait_done(100);
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b0;
    chk_gap    = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Single read
    model_rd_data = D0;
    push_txn(0, 23'h000234, '0, D0);
    bus.rd_addr = 23'h000234;
    bus.rd_req  = 1'b1;
    wait_done(100);
    check("done_state_busy", bus.arb_busy, 1);
    bus.rd_req = 1'b0;
    repeat (2) @(negedge sys_clk);
    check("idle_after_done", bus.arb_busy, 0);

    // Single write
    push_txn(1, 23'h000234, D0, '0);
    bus.wr_addr = 23'h000234;
    bus.wr_data = D0;
    bus.wr_req  = 1'b1;
    wait_done(100);
    check("wr_done_lag", cyc - busy_fall_cyc, 1);
    bus.wr_req = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Read timeout: rd_data keeps the previous read value
    mode = M_NO_BUSY;
    check("err_before_to", bus.timeout_err, 0);
    push_txn(0, 23'h000ABC, '0, D0);
    bus.rd_addr = 23'h000ABC;
    bus.rd_req  = 1'b1;
    wait_done(400);
    bus.rd_req = 1'b0;
    check("to_latency", cyc - last_grant_cyc, TO + 1);
    check("to_rd_en", bus.mem_rd_enable, 0);
    check("to_err", bus.timeout_err, 1);
    mode = M_NORMAL;
    repeat (3) @(negedge sys_clk);

    push_txn(1, 23'h000001, D3, '0);
    bus.wr_addr = 23'h000001;
    bus.wr_data = D3;
    bus.wr_req  = 1'b1;
    wait_done(100);
    bus.wr_req = 1'b0;
    check("err_sticky", bus.timeout_err, 1);
    repeat (3) @(negedge sys_clk);

    // Request held through DONE is not regranted
    model_rd_data = D3;
    push_txn(0, 23'h055555, '0, D3);
    bus.rd_addr = 23'h055555;
    bus.rd_req  = 1'b1;
    wait_done(100);
    @(posedge sys_clk);
    #1;
    bus.rd_req = 1'b0;
    gc = grant_cnt;
    repeat (20) @(negedge sys_clk);
    check("held_req_no_regrant", grant_cnt - gc, 0);

    // Async reset while in RD_WAIT
    mode = M_NO_READY;
    grant_q.push_back('{is_wr: 1'b0, addr: 23'h00F0F0, data: '0});
    bus.rd_addr = 23'h00F0F0;
    bus.rd_req  = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (bus.mem_busy && !bus.mem_rd_enable && bus.arb_busy) break;
    end
    check("reach_rd_wait",
          {bus.mem_busy, bus.mem_rd_enable, bus.arb_busy}, 3'b101);
    repeat (2) @(negedge sys_clk);
    #2;
    rst        = 1'b1;
    bus.rd_req = 1'b0;
    #1;
    check("arst_rd_en", bus.mem_rd_enable, 0);
    check("arst_rd_done", bus.rd_done, 0);
    check("arst_arb_busy", bus.arb_busy, 0);
    check("arst_err", bus.timeout_err, 0);
    check("arst_rd_data", bus.rd_data, 0);
    repeat (3) @(negedge sys_clk);
    rst  = 1'b0;
    mode = M_NORMAL;
    repeat (3) @(negedge sys_clk);
    check("post_rst_idle", bus.arb_busy, 0);

    model_rd_data = D2;
    push_txn(0, 23'h000002, '0, D2);
    bus.rd_addr = 23'h000002;
    bus.rd_req  = 1'b1;
    wait_done(100);
    bus.rd_req = 1'b0;
    repeat (3) @(negedge sys_clk);

    check("grant_q_empty", grant_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single sdram_controller port between two requesters: the display/char-gen fetch path (read) and the text-buffer update path (write).
- Owns the controller's enable/busy/rd_ready handshake, so requesters see a simple req/done protocol.
- Sits in the sys_clk domain, between the main system logic and i_sdram_controller.
- Alternates grants on contention and guards every transfer with a watchdog.

Parameters:
- ADDR_WIDTH, 23, SDRAM word address width (bank+row+col).
- DATA_WIDTH, 128, burst data width.
- TIMEOUT_CYCLES, 255, max cycles spent in any request/wait state before abort.
- TIMEOUT_WIDTH, 8, watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- sys_clk  in  1  system clock (96 MHz).
- rst  in  1  reset, asynchronous, active-high.
- rd_req  in  1  read request; held high until rd_done.
- rd_addr  in  ADDR_WIDTH  read address; stable while rd_req is high.
- rd_done  out  1  one-cycle pulse; read complete, rd_data valid.
- rd_data  out  DATA_WIDTH  last read data; holds until the next read completes.
- wr_req  in  1  write request; held high until wr_done.
- wr_addr  in  ADDR_WIDTH  write address; stable while wr_req is high.
- wr_data  in  DATA_WIDTH  write data; stable while wr_req is high.
- wr_done  out  1  one-cycle pulse; write complete.
- mem_rd_addr  out  ADDR_WIDTH  to controller rd_addr.
- mem_rd_enable  out  1  to controller rd_enable.
- mem_wr_addr  out  ADDR_WIDTH  to controller wr_addr.
- mem_wr_data  out  DATA_WIDTH  to controller wr_data.
- mem_wr_enable  out  1  to controller wr_enable.
- mem_busy  in  1  controller busy.
- mem_rd_ready  in  1  controller read data valid.
- mem_rd_data  in  DATA_WIDTH  controller read data.
- arb_busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Single clock, sys_clk. Reset is asynchronous and active-high on rst.
- All outputs are registered. On rst, every output goes to 0 immediately, state goes to IDLE and last_grant goes to WRITE.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE, arbitration:
  - Only rd_req high: grant the read.
  - Only wr_req high: grant the write.
  - Both high: grant the type opposite to last_grant, then update last_grant.
  - With last_grant = WRITE at reset, the first contended grant is a read.
- IDLE, read grant: on the next edge latch rd_addr into mem_rd_addr, set mem_rd_enable=1, go to RD_REQ.
- IDLE, write grant: on the next edge latch wr_addr/wr_data into mem_wr_addr/mem_wr_data, set mem_wr_enable=1, go to WR_REQ.
- RD_REQ: when mem_busy=1, set mem_rd_enable=0 and go to RD_WAIT.
- RD_WAIT: when mem_rd_ready=1, capture mem_rd_data into rd_data, set rd_done=1 for one cycle, go to DONE.
- WR_REQ: when mem_busy=1, set mem_wr_enable=0 and go to WR_WAIT.
- WR_WAIT: when mem_busy=0, set wr_done=1 for one cycle, go to DONE.
- DONE: lasts exactly one cycle, then IDLE. Requests are ignored here, so a requester dropping req on seeing done is never regranted.
- Minimum grant-to-grant spacing is 1 DONE cycle + 1 IDLE cycle.
- Watchdog:
  - Counter clears on every state transition and increments in RD_REQ, RD_WAIT, WR_REQ and WR_WAIT.
  - At count == TIMEOUT_CYCLES: deassert both enables, set timeout_err=1, pulse the matching done, go to DONE.
  - On a read timeout, rd_data is left unchanged.
- mem_rd_ready outside RD_WAIT is ignored. A mem_busy rise while in IDLE is ignored.
- Any request-input change while not in IDLE is ignored; inputs are sampled only at grant.
- Address and data are passed through at full ADDR_WIDTH/DATA_WIDTH with no arithmetic.
- Reset mid-transfer: enables drop at once and no done is issued. Requesters must re-request after reset.

Decomposition:
- Shared package sdram_arb_pkg holds:
  - state encoding localparams (IDLE..DONE);
  - last_grant encoding (READ=0, WRITE=1);
  - default widths.
- The FSM and watchdog stay in one module; no sub-module is needed.

Test Plan:
- Single read: rd_req, rd_addr=23'h000234; model raises busy 3 cycles after enable and rd_ready 10 cycles later with 128'h0123456789ABCDEF0123456789ABCDEF -> mem_rd_enable high until busy, then one rd_done pulse with rd_data equal to that value.
- Single write: wr_req, wr_addr=23'h000234, wr_data=128'h0123...CDEF -> mem_wr_enable held until busy, mem_wr_data matches; wr_done pulses exactly one cycle after busy falls.
- Contention after reset: rd_req and wr_req high together in the same cycle -> read served first, then write; repeat with both held -> strict alternation R,W,R,W with a 2-cycle gap between grants.
- Timeout: rd_req high, model never raises busy -> mem_rd_enable drops, rd_done pulses and timeout_err=1 after TIMEOUT_CYCLES; a following write completes normally and timeout_err stays 1.
- Held req across done: requester keeps rd_req high one cycle past rd_done -> no second grant issued.
- Async reset in RD_WAIT: rst asserted -> mem_rd_enable, rd_done, arb_busy and timeout_err go to 0 without a clock edge; after release, state is IDLE.
